// File: rtl/cos_sin_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cos_sin_lut_pipe
// Purpose  : 3-stage streaming cos/sin generator, quarter-wave ROM with
//            quadrant folding and valid/ready backpressure.
//            Build option COS_SIN_MAGSIGN_EN: magnitude outputs + sign ports.
// Revision : 1.0  initial release
// ============================================================================
module cos_sin_lut_pipe #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [AMP_W-1:0]   cos_out,
  output logic [AMP_W-1:0]   sin_out,
`ifdef COS_SIN_MAGSIGN_EN
  output logic               cos_sign_out,
  output logic               sin_sign_out,
`endif
  output logic               valid_out,
  input  logic               ready_in
);

  localparam int                 c_n      = 1 << LUT_AW;
  localparam int                 c_f      = 60;
  localparam logic [LUT_AW:0]    c_n_addr = (LUT_AW+1)'(c_n);
  localparam logic [AMP_W-1:0]   c_zero   = '0;
  localparam logic signed [127:0] c_pi_fx = 128'sh3243F6A8885A308D;
  localparam logic signed [127:0] c_amp   = (128'sd1 <<< (AMP_W-1)) - 128'sd1;

  // Quarter-wave entry round((2^(AMP_W-1)-1)*sin(k*pi/(2N))), evaluated at
  // elaboration with a 60-bit fixed-point Taylor series (no image file needed).
  function automatic logic [AMP_W-2:0] qsin(input int k);
    logic signed [127:0] x;
    logic signed [127:0] term;
    logic signed [127:0] acc;
    x    = (128'(k) * c_pi_fx) >>> (LUT_AW + 1);
    term = x;
    acc  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x) >>> c_f;
      term = (term * x) >>> c_f;
      term = -term / 128'(2 * n * (2 * n + 1));
      acc  = acc + term;
    end
    acc = (acc * c_amp + (128'sd1 <<< (c_f - 1))) >>> c_f;
    return acc[AMP_W-2:0];
  endfunction

  logic [AMP_W-2:0] w_rom [0:c_n];
  for (genvar k = 0; k <= c_n; k++) begin : g_rom
    localparam logic [AMP_W-2:0] c_val = qsin(k);
    assign w_rom[k] = c_val;
  end

  logic              w_adv;
  logic              w_unused_phase;
  logic              r_v0, r_v1;
  logic [1:0]        r_q0, r_q1;
  logic [LUT_AW-1:0] r_i0;
  logic [LUT_AW:0]   r_ni0;
  logic [LUT_AW:0]   w_cos_addr, w_sin_addr;
  logic [AMP_W-2:0]  r_mc1, r_ms1;
  logic              w_cos_neg, w_sin_neg;
  logic [AMP_W-1:0]  w_cos_ext, w_sin_ext;

  assign w_adv          = !valid_out || ready_in;
  assign ready_out      = w_adv && rst_n_in;
  assign w_unused_phase = ^phase_in;

  // S0: split phase into quadrant and quarter-table index
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v0  <= 1'b0;
      r_q0  <= '0;
      r_i0  <= '0;
      r_ni0 <= '0;
    end else if (w_adv) begin
      r_v0  <= valid_in;
      r_q0  <= phase_in[PHASE_W-1 -: 2];
      r_i0  <= phase_in[PHASE_W-3 -: LUT_AW];
      r_ni0 <= c_n_addr - {1'b0, phase_in[PHASE_W-3 -: LUT_AW]};
    end
  end

  // Odd quadrants swap which address feeds cos and which feeds sin
  assign w_cos_addr = r_q0[0] ? {1'b0, r_i0} : r_ni0;
  assign w_sin_addr = r_q0[0] ? r_ni0 : {1'b0, r_i0};

  // S1: dual-read synchronous ROM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v1  <= 1'b0;
      r_q1  <= '0;
      r_mc1 <= '0;
      r_ms1 <= '0;
    end else if (w_adv) begin
      r_v1  <= r_v0;
      r_q1  <= r_q0;
      r_mc1 <= w_rom[w_cos_addr];
      r_ms1 <= w_rom[w_sin_addr];
    end
  end

  assign w_cos_neg = r_q1[1] ^ r_q1[0];
  assign w_sin_neg = r_q1[1];
  assign w_cos_ext = {1'b0, r_mc1};
  assign w_sin_ext = {1'b0, r_ms1};

  // S2: apply quadrant signs and register the outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out    <= 1'b0;
      cos_out      <= '0;
      sin_out      <= '0;
`ifdef COS_SIN_MAGSIGN_EN
      cos_sign_out <= 1'b1;
      sin_sign_out <= 1'b1;
`endif
    end else if (w_adv) begin
      valid_out    <= r_v1;
`ifdef COS_SIN_MAGSIGN_EN
      cos_out      <= w_cos_ext;
      sin_out      <= w_sin_ext;
      cos_sign_out <= !w_cos_neg || (r_mc1 == '0);
      sin_sign_out <= !w_sin_neg || (r_ms1 == '0);
`else
      cos_out      <= w_cos_neg ? (c_zero - w_cos_ext) : w_cos_ext;
      sin_out      <= w_sin_neg ? (c_zero - w_sin_ext) : w_sin_ext;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cos_sin_lut_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for cos_sin_lut_pipe: directed steps, scoreboard queue, output monitor.
module tb_cos_sin_lut_pipe;

  localparam real c_pi = 3.14159265358979323846;

  typedef struct {
    logic [15:0] ph;
    int          c;
    int          s;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] phase_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        valid_out;
  logic        ready_in;
`ifdef COS_SIN_MAGSIGN_EN
  logic        cos_sign_out;
  logic        sin_sign_out;
`endif

  exp_t sb[$];
  int   tq[0:256];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   bound_err = 0;
  bit   sweep_on = 1'b0;

  cos_sin_lut_pipe #(.PHASE_W(16), .LUT_AW(8), .AMP_W(16)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .phase_in    (phase_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .cos_out     (cos_out),
    .sin_out     (sin_out),
`ifdef COS_SIN_MAGSIGN_EN
    .cos_sign_out(cos_sign_out),
    .sin_sign_out(sin_sign_out),
`endif
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model(input logic [15:0] p, output int c, output int s);
    int i;
    i = int'(p[13:6]);
    case (p[15:14])
      2'd0:    begin c =  tq[256-i]; s =  tq[i];     end
      2'd1:    begin c = -tq[i];     s =  tq[256-i]; end
      2'd2:    begin c = -tq[256-i]; s = -tq[i];     end
      default: begin c =  tq[i];     s = -tq[256-i]; end
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present p until accepted; leaves valid_in high so calls chain back-to-back.
  task automatic send(input logic [15:0] p, input int ec, input int es);
    int guard;
    guard    = 0;
    phase_in = p;
    valid_in = 1'b1;
    @(negedge clk_in); #2;
    while (!ready_out && guard < 200) begin
      @(negedge clk_in); #2;
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout: observed ready_out 0 for %0d cycles expected 1", guard);
    end else begin
      sb.push_back('{p, ec, es});
    end
    @(posedge clk_in); #1;
  endtask

  task automatic send_model(input logic [15:0] p);
    int c, s;
    model(p, c, s);
    send(p, c, s);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk_in); #1;
      guard++;
    end
    chk(tag, sb.size(), 0);
  endtask

  // Output monitor: every transfer pops one expected result
  exp_t e;
  int   oc, os;
  real  rc, rs;
  always begin
    @(negedge clk_in); #2;
    if (rst_n_in && valid_out && ready_in) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_output: observed cos %0d sin %0d expected no output",
               cos_out, sin_out);
      end else begin
        e = sb.pop_front();
`ifdef COS_SIN_MAGSIGN_EN
        oc = cos_sign_out ? int'(cos_out) : -int'(cos_out);
        os = sin_sign_out ? int'(sin_out) : -int'(sin_out);
        assert (cos_out === 16'(iabs(e.c)) && sin_out === 16'(iabs(e.s)) &&
                cos_sign_out === (e.c >= 0) && sin_sign_out === (e.s >= 0)) else begin
          miscompares++;
          $error("FAIL out_%h: observed cos %0d/%0b sin %0d/%0b expected cos %0d sin %0d",
                 e.ph, cos_out, cos_sign_out, sin_out, sin_sign_out, e.c, e.s);
        end
`else
        oc = int'($signed(cos_out));
        os = int'($signed(sin_out));
        assert (oc === e.c && os === e.s) else begin
          miscompares++;
          $error("FAIL out_%h: observed cos %0d sin %0d expected cos %0d sin %0d",
                 e.ph, oc, os, e.c, e.s);
        end
`endif
        if (sweep_on) begin
          rc = 32767.0 * $cos(2.0 * c_pi * real'(e.ph) / 65536.0);
          rs = 32767.0 * $sin(2.0 * c_pi * real'(e.ph) / 65536.0);
          // 1 LSB rounding + 6 truncated phase bits (63/65536 turn ~ 198 LSB)
          if ((real'(oc) - rc) > 200.0 || (rc - real'(oc)) > 200.0 ||
              (real'(os) - rs) > 200.0 || (rs - real'(os)) > 200.0)
            bound_err++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed run still active at 2 ms expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, vcnt, held_c, held_s;
    for (int k = 0; k <= 256; k++)
      tq[k] = $rtoi($floor(32767.0 * $sin(real'(k) * c_pi / 512.0) + 0.5));

    rst_n_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    phase_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_cos", cos_out, 0);
    chk("reset_sin", sin_out, 0);
    chk("reset_ready_out", ready_out, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("ready_after_reset", ready_out, 1);

    // Axis points back-to-back
    send(16'h0000,  32767,      0);
    send(16'h4000,      0,  32767);
    send(16'h8000, -32767,      0);
    send(16'hC000,      0, -32767);
    valid_in = 1'b0;
    drain("axis_drain");

    // Latency: result appears on the 3rd edge counting the accept edge
    send(16'h2000, 23170, 23170);
    valid_in = 1'b0;
    chk("lat_edge1", valid_out, 0);
    @(posedge clk_in); #1;
    chk("lat_edge2", valid_out, 0);
    @(posedge clk_in); #1;
    chk("lat_edge3", valid_out, 1);
    drain("lat_drain");
    send(16'hE000, 23170, -23170);
    valid_in = 1'b0;
    drain("e000_drain");

    // Backpressure: 4-cycle ready_in stall in the middle of 8 samples
    fork
      begin
        for (int k = 0; k < 8; k++) send_model(16'h1234 + 16'(k) * 16'h1111);
        valid_in = 1'b0;
      end
      begin
        repeat (5) @(posedge clk_in);
        #2;
        ready_in = 1'b0;
        held_c   = int'(cos_out);
        held_s   = int'(sin_out);
        chk("stall_valid_out", valid_out, 1);
        repeat (4) begin
          @(negedge clk_in); #2;
          chk("stall_ready_out", ready_out, 0);
          chk("stall_cos_held", cos_out, held_c);
          chk("stall_sin_held", sin_out, held_s);
        end
        @(posedge clk_in); #2;
        ready_in = 1'b1;
      end
    join
    drain("stall_drain");

    // Reset with three samples in flight
    send_model(16'h0100);
    send_model(16'h5555);
    send_model(16'hAAAA);
    valid_in = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    sb.delete();
    chk("rst_mid_valid_out", valid_out, 0);
    chk("rst_mid_cos", cos_out, 0);
    chk("rst_mid_sin", sin_out, 0);
    chk("rst_mid_ready_out", ready_out, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(posedge clk_in); #1;
      if (valid_out) vcnt++;
    end
    chk("rst_no_stale", vcnt, 0);
    send_model(16'h7777);
    valid_in = 1'b0;
    drain("post_rst_drain");

    // Full phase sweep at one sample per clock
    c0       = cyc;
    sweep_on = 1'b1;
    for (int k = 0; k < 65536; k++) send_model(16'(k));
    valid_in = 1'b0;
    chk("sweep_cycles", cyc - c0, 65536);
    drain("sweep_drain");
    sweep_on = 1'b0;
    chk("sweep_bound_err", bound_err, 0);

    repeat (2) @(posedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
